vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front-porch clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync-pulse clocks.
REQ-004 Parameter H_BACK, default 48, horizontal back-porch clocks; H_TOTAL = sum of the four H parameters (default 800).
REQ-005 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front-porch lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync-pulse lines.
REQ-008 Parameter V_BACK, default 33, vertical back-porch lines; V_TOTAL = sum of the four V parameters (default 525).
REQ-009 vga_clk  input  1  pixel clock; the block's only clock; all state changes on its rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 DrawX  output  10  current horizontal pixel position, 0..H_TOTAL-1.
REQ-012 DrawY  output  10  current line, 0..V_TOTAL-1.
REQ-013 hs  output  1  horizontal sync, active low.
REQ-014 vs  output  1  vertical sync, active low.
REQ-015 blank  output  1  1 = visible region (pixel renderers drive color), 0 = blanking.
REQ-016 line_start  output  1  one-cycle pulse while DrawX = 0.
REQ-017 frame_start  output  1  one-cycle pulse while DrawX = 0 and DrawY = 0.
REQ-018 frame_count  output  16  number of completed frames since reset.

Function
REQ-019 All outputs are registered; no combinational path from any input to any output.
REQ-020 DrawX increments by 1 on each vga_clk edge; at H_TOTAL-1 it wraps to 0 on the next edge.
REQ-021 DrawY increments by 1 only on the edge where DrawX wraps; at V_TOTAL-1 with DrawX = H_TOTAL-1 it wraps to 0.
REQ-022 In every cycle, hs, vs, blank, line_start and frame_start describe the DrawX/DrawY values present in that same cycle (zero skew between position and control).
REQ-023 hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751), else 1.
REQ-024 vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), else 1; vs changes only at the DrawX = 0 boundary.
REQ-025 blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE, except while reset is asserted (REQ-029).
REQ-026 frame_count increments by 1, modulo 2^16, in the same edge that moves the position from (H_TOTAL-1, V_TOTAL-1) to (0,0); 16'hFFFF wraps to 0.
REQ-027 frame_start asserts exactly once per V_TOTAL*H_TOTAL cycles (420000 at defaults), in the same cycle frame_count shows its new value.
REQ-028 Counter widths: internal comparisons are unsigned, with no overflow at the 10-bit limit for the default parameters (H_TOTAL, V_TOTAL <= 1024).

Reset
REQ-029 While reset = 1: DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 0, line_start = 0, frame_start = 0, frame_count = 0, all taking effect asynchronously.
REQ-030 On the first vga_clk edge after reset deasserts, the position advances to (1,0) with blank = 1; the next frame_start occurs when (0,0) is next reached, 420000 edges later at defaults.
REQ-031 Reset asserted mid-line or mid-frame aborts immediately to REQ-029 values with no partial sync pulse held; frame_count does not increment.

Verification
REQ-032 Release reset, run 800 clocks -> DrawX sequence 1..799,0; hs low exactly for DrawX 656..751 (96 cycles); blank high for DrawX 1..639 of line 0; line_start high at DrawX = 0 only.
REQ-033 Run one full frame -> vs low for exactly 1600 clocks (lines 490..491); DrawY wraps 524 -> 0 when DrawX wraps 799 -> 0; frame_start pulses once, frame_count goes 0 -> 1.
REQ-034 Check every cycle of two frames -> blank = 1 iff DrawX < 640 and DrawY < 480; 307200 blank-high cycles per frame.
REQ-035 Assert reset asynchronously at DrawX = 700, DrawY = 491 (hs and vs both low) -> hs = 1, vs = 1, blank = 0, DrawX = 0, DrawY = 0, frame_count = 0 before the next clock edge.
REQ-036 Force frame_count to 16'hFFFF (or run 65536 frames with reduced parameters H_TOTAL = 8, V_TOTAL = 4) -> wraps to 0 on the next frame boundary with frame_start high.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster position counter and sync/blank generator for a VGA-style display.
// Controls are registered from the next position so they line up with DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       x_wrap;
    logic       y_wrap;
    logic       frame_wrap;

    always_comb begin
        x_wrap     = (DrawX == H_LAST);
        y_wrap     = (DrawY == V_LAST);
        frame_wrap = x_wrap && y_wrap;
        x_next     = x_wrap ? 10'd0 : DrawX + 10'd1;
        y_next     = DrawY;
        if (x_wrap) begin
            y_next = y_wrap ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Decoding x_next/y_next keeps every control aligned with the position it describes.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            hs          <= !((x_next >= HS_START) && (x_next < HS_END));
            vs          <= !((y_next >= VS_START) && (y_next < VS_END));
            blank       <= (x_next < H_VIS) && (y_next < V_VIS);
            line_start  <= (x_next == 10'd0);
            frame_start <= (x_next == 10'd0) && (y_next == 10'd0);
            if (frame_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (32 x 20) so whole frames fit.
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int VV = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .line_start (line_start),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int x, y, hs, vs, blank, ls, fs, fc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   t     = 0;
    int   base  = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs t edges after reset release, from plain raster arithmetic.
    function automatic exp_t model_at(input int tt);
        exp_t e;
        int p;
        p       = tt % FR;
        e.x     = p % HT;
        e.y     = p / HT;
        e.hs    = (e.x >= HV + HF && e.x < HV + HF + HS) ? 0 : 1;
        e.vs    = (e.y >= VV + VF && e.y < VV + VF + VS) ? 0 : 1;
        e.blank = (e.x < HV && e.y < VV) ? 1 : 0;
        e.ls    = (e.x == 0) ? 1 : 0;
        e.fs    = (p == 0) ? 1 : 0;
        e.fc    = (base + tt / FR) & 32'hFFFF;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.x = 0; e.y = 0; e.hs = 1; e.vs = 1;
        e.blank = 0; e.ls = 0; e.fs = 0; e.fc = 0;
        return e;
    endfunction

    always @(negedge vga_clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("DrawX",       int'(DrawX),       mon_e.x);
            check("DrawY",       int'(DrawY),       mon_e.y);
            check("hs",          int'(hs),          mon_e.hs);
            check("vs",          int'(vs),          mon_e.vs);
            check("blank",       int'(blank),       mon_e.blank);
            check("line_start",  int'(line_start),  mon_e.ls);
            check("frame_start", int'(frame_start), mon_e.fs);
            check("frame_count", int'(frame_count), mon_e.fc);
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
            if (reset) begin
                sb.push_back(reset_exp());
            end else begin
                t++;
                sb.push_back(model_at(t));
            end
        end
    endtask

    // Reset is raised 2 time units after an edge, so the monitor sees it before the next edge.
    task automatic async_reset(input int hold);
        exp_t pre;
        @(posedge vga_clk);
        #1;
        pre = model_at(t + 1);
        check("pre_reset_hs", int'(hs), pre.hs);
        check("pre_reset_vs", int'(vs), pre.vs);
        #1;
        reset = 1'b1;
        t     = 0;
        base  = 0;
        sb.push_back(reset_exp());
        run(hold);
        @(posedge vga_clk);
        #1;
        sb.push_back(reset_exp());
        #2;
        reset = 1'b0;
    endtask

    task automatic run_to_phase(input int ph);
        run(((ph - (t % FR)) % FR + FR) % FR);
    endtask

    initial begin
        run(3);
        #2;
        reset = 1'b0;
        t = 0;

        run(2 * FR + 5);

        // Abort in the middle of both sync pulses: x = 22, y = 15.
        run_to_phase(15 * HT + 22 - 1);
        async_reset($urandom_range(1, 4));
        run($urandom_range(FR / 2, 3 * FR / 2));

        run($urandom_range(0, FR - 1));
        async_reset($urandom_range(0, 3));
        run(FR + $urandom_range(0, 50));

        // Preload the frame counter to its maximum and watch it wrap at the next boundary.
        run_to_phase($urandom_range(100, 400));
        @(posedge vga_clk);
        #1;
        force dut.frame_count = 16'hFFFF;
        t++;
        base = (32'hFFFF - t / FR) & 32'hFFFF;
        sb.push_back(model_at(t));
        run(1);
        release dut.frame_count;
        run(FR + $urandom_range(5, 40));

        @(negedge vga_clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
